uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx_sampler.sv | 43 ++++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, prescale constants and default width
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PRESC_8       = 8;
  localparam int PRESC_16      = 16;
  localparam int PRESC_32      = 32;
  localparam int DEFAULT_WIDTH = 8;

  // Anything other than 16 or 32 runs at the slowest legal oversampling rate.
  function automatic int legal_prescale(input int p);
    return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and result signals of uart_rx
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PRESC_W = 6
);

  logic               rx_in;
  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               par_typ;
  logic [WIDTH-1:0]   p_data;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;
  logic               busy;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter, 3-sample majority vote and bit-done strobe
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  input  logic               rx_in,
  output logic               bit_val,
  output logic               bit_done
);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [2:0]         samples;

  assign half     = presc >> 1;
  assign bit_done = run && (edge_cnt == presc - 1'b1);
  // All three samples precede the wrap cycle for every legal prescale.
  assign bit_val  = (samples[0] & samples[1]) |
                    (samples[0] & samples[2]) |
                    (samples[1] & samples[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      samples  <= '1;
    end else begin
      if (!run || bit_done) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
      if (run) begin
        if (edge_cnt == half - 1'b1) samples[0] <= rx_in;
        if (edge_cnt == half)        samples[1] <= rx_in;
        if (edge_cnt == half + 1'b1) samples[2] <= rx_in;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver top: FSM, shift register and frame checks
// Parity support is built only when UART_RX_PARITY_CHECK_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PRESC_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  rx_state_t          state;
  rx_state_t          next_state;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_legal;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   p_data_q;
  logic               data_valid_q;
  logic               stp_err_q;
  logic               armed;
  logic               run;
  logic               bit_val;
  logic               bit_done;
  logic               par_en_eff;
  logic               frame_par_bad;

  assign presc_legal = PRESC_W'(legal_prescale(int'(bus.prescale)));
  assign run         = (state != IDLE);

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .presc    (presc_q),
    .rx_in    (bus.rx_in),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

`ifdef UART_RX_PARITY_CHECK_EN
  logic par_en_q;
  logic par_typ_q;
  logic par_bad_q;
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      if (state == IDLE) begin
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
      end
      if (state == START) begin
        par_bad_q <= 1'b0;
      end
      if (state == PARITY && bit_done) begin
        par_bad_q <= ((^shift_q) ^ par_typ_q) != bit_val;
      end
      if (state == STOP && bit_done) begin
        par_err_q <= par_bad_q;
      end
    end
  end

  assign par_en_eff    = par_en_q;
  assign frame_par_bad = par_bad_q;
  assign bus.par_err   = par_err_q;
`else
  assign par_en_eff    = 1'b0;
  assign frame_par_bad = 1'b0;
  assign bus.par_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start is only accepted once the line has been seen high since reset,
  // so a reset landing mid-frame waits for a genuine falling edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!bus.rx_in && armed) next_state = START;
      end
      START: begin
        if (bit_done) next_state = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && bit_cnt == BIT_LAST) next_state = par_en_eff ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) next_state = STOP;
      end
      STOP: begin
        if (bit_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= PRESC_W'(PRESC_8);
      bit_cnt      <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      stp_err_q    <= 1'b0;
      armed        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      stp_err_q    <= 1'b0;
      if (bus.rx_in) armed <= 1'b1;
      case (state)
        IDLE: begin
          presc_q <= presc_legal;
        end
        START: begin
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= {bit_val, shift_q[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!frame_par_bad && bit_val) begin
              data_valid_q <= 1'b1;
              p_data_q     <= shift_q;
            end
            stp_err_q <= !bit_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = run;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (parity cases under UART_RX_PARITY_CHECK_EN)
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_if #(.WIDTH(8), .PRESC_W(6)) bus ();

  uart_rx #(.WIDTH(8), .PRESC_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;
  int dv_total = 0;
  int pe_total = 0;
  int se_total = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_pdata = 8'h00;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_total  = dv_total + 1;
      prev_data = last_data;
      last_data = bus.p_data;
    end
    if (bus.par_err === 1'b1) pe_total = pe_total + 1;
    if (bus.stp_err === 1'b1) se_total = se_total + 1;
  end

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [5:0] p, input logic en, input logic typ);
    bus.prescale = p;
    bus.par_en   = en;
    bus.par_typ  = typ;
  endtask

  task automatic send_bit(input logic b, input int p, input int flip_at);
    for (int i = 0; i < p; i++) begin
      bus.rx_in = (i == flip_at) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic with_par,
                            input logic par_bit, input logic stop_bit, input int noise_bit);
    send_bit(1'b0, p, -1);
    for (int k = 0; k < 8; k++) begin
      send_bit(d[k], p, (k == noise_bit) ? (p / 2 + 1) : -1);
    end
    if (with_par) send_bit(par_bit, p, -1);
    send_bit(stop_bit, p, -1);
    bus.rx_in = 1'b1;
  endtask

  task automatic test_reset;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", bus.busy); else passed++;
    total++; if (bus.p_data !== 8'h00) $display("FAIL reset_p_data got %h expected 00", bus.p_data); else passed++;
    total++; if (bus.data_valid !== 1'b0) $display("FAIL reset_data_valid got %b expected 0", bus.data_valid); else passed++;
    total++; if (bus.par_err !== 1'b0 || bus.stp_err !== 1'b0)
      $display("FAIL reset_errs got %b%b expected 00", bus.par_err, bus.stp_err); else passed++;
    rst = 1'b0;
    idle(4);
    total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b expected 0", bus.busy); else passed++;
  endtask

`ifdef UART_RX_PARITY_CHECK_EN
  task automatic test_even_parity;
    int dv0 = dv_total, pe0 = pe_total, se0 = se_total;
    set_cfg(6'd8, 1'b1, 1'b0);
    send_frame(8'hCB, 8, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    exp_pdata = 8'hCB;
    total++; if (dv_total - dv0 !== 1) $display("FAIL even_dv_count got %0d expected 1", dv_total - dv0); else passed++;
    total++; if (last_data !== 8'hCB) $display("FAIL even_data got %h expected cb", last_data); else passed++;
    total++; if (pe_total - pe0 !== 0 || se_total - se0 !== 0)
      $display("FAIL even_errs got pe=%0d se=%0d expected 0 0", pe_total - pe0, se_total - se0); else passed++;
  endtask

  task automatic test_odd_parity;
    int dv0 = dv_total, pe0 = pe_total;
    set_cfg(6'd16, 1'b1, 1'b1);
    send_frame(8'hCB, 16, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    total++; if (dv_total - dv0 !== 1) $display("FAIL odd_dv_count got %0d expected 1", dv_total - dv0); else passed++;
    total++; if (last_data !== 8'hCB) $display("FAIL odd_data got %h expected cb", last_data); else passed++;
    dv0 = dv_total;
    send_frame(8'hCB, 16, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    total++; if (pe_total - pe0 !== 1) $display("FAIL odd_par_err got %0d expected 1", pe_total - pe0); else passed++;
    total++; if (dv_total - dv0 !== 0) $display("FAIL odd_bad_dv got %0d expected 0", dv_total - dv0); else passed++;
    total++; if (bus.p_data !== exp_pdata) $display("FAIL odd_hold got %h expected %h", bus.p_data, exp_pdata); else passed++;
  endtask
`else
  task automatic test_parity_ignored;
    int dv0 = dv_total, pe0 = pe_total;
    set_cfg(6'd8, 1'b1, 1'b1);
    send_frame(8'hCB, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    exp_pdata = 8'hCB;
    total++; if (dv_total - dv0 !== 1) $display("FAIL nopar_dv_count got %0d expected 1", dv_total - dv0); else passed++;
    total++; if (last_data !== 8'hCB) $display("FAIL nopar_data got %h expected cb", last_data); else passed++;
    total++; if (pe_total - pe0 !== 0) $display("FAIL nopar_par_err got %0d expected 0", pe_total - pe0); else passed++;
  endtask
`endif

  task automatic test_stop_error;
    int dv0 = dv_total, se0 = se_total;
    set_cfg(6'd16, 1'b0, 1'b0);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    total++; if (se_total - se0 !== 1) $display("FAIL stop_err_count got %0d expected 1", se_total - se0); else passed++;
    total++; if (dv_total - dv0 !== 0) $display("FAIL stop_dv got %0d expected 0", dv_total - dv0); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL stop_idle got %b expected 0", bus.busy); else passed++;
    total++; if (bus.p_data !== exp_pdata) $display("FAIL stop_hold got %h expected %h", bus.p_data, exp_pdata); else passed++;
    idle(4);
  endtask

  task automatic test_glitch;
    int dv0 = dv_total, pe0 = pe_total, se0 = se_total;
    set_cfg(6'd8, 1'b0, 1'b0);
    bus.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_in = 1'b1;
    total++; if (bus.busy !== 1'b1) $display("FAIL glitch_busy_start got %b expected 1", bus.busy); else passed++;
    repeat (8) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL glitch_busy_end got %b expected 0", bus.busy); else passed++;
    total++; if (dv_total != dv0 || pe_total != pe0 || se_total != se0)
      $display("FAIL glitch_pulses got %0d expected 0", (dv_total - dv0) + (pe_total - pe0) + (se_total - se0)); else passed++;
    idle(4);
  endtask

  task automatic test_back_to_back;
    int dv0 = dv_total;
    set_cfg(6'd32, 1'b0, 1'b0);
    send_frame(8'hA5, 32, 1'b0, 1'b0, 1'b1, 2);
    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1, -1);
    idle(8);
    exp_pdata = 8'h3C;
    total++; if (dv_total - dv0 !== 2) $display("FAIL b2b_dv_count got %0d expected 2", dv_total - dv0); else passed++;
    total++; if (prev_data !== 8'hA5) $display("FAIL b2b_first got %h expected a5", prev_data); else passed++;
    total++; if (last_data !== 8'h3C) $display("FAIL b2b_second got %h expected 3c", last_data); else passed++;
  endtask

  task automatic test_presc_change;
    int dv0 = dv_total;
    logic [7:0] d = 8'h96;
    set_cfg(6'd16, 1'b0, 1'b0);
    send_bit(1'b0, 16, -1);
    bus.prescale = 6'd8;
    for (int k = 0; k < 8; k++) send_bit(d[k], 16, -1);
    send_bit(1'b1, 16, -1);
    idle(4);
    exp_pdata = 8'h96;
    total++; if (dv_total - dv0 !== 1) $display("FAIL presc_chg_dv got %0d expected 1", dv_total - dv0); else passed++;
    total++; if (last_data !== 8'h96) $display("FAIL presc_chg_data got %h expected 96", last_data); else passed++;
  endtask

  task automatic test_illegal_presc;
    int dv0 = dv_total;
    set_cfg(6'd5, 1'b0, 1'b0);
    send_frame(8'h69, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    exp_pdata = 8'h69;
    total++; if (dv_total - dv0 !== 1) $display("FAIL illegal_presc_dv got %0d expected 1", dv_total - dv0); else passed++;
    total++; if (last_data !== 8'h69) $display("FAIL illegal_presc_data got %h expected 69", last_data); else passed++;
  endtask

  task automatic test_mid_reset;
    int dv0 = dv_total, pe0 = pe_total, se0 = se_total;
    logic [7:0] d = 8'h5A;
    set_cfg(6'd8, 1'b0, 1'b0);
    send_bit(1'b0, 8, -1);
    for (int k = 0; k < 4; k++) send_bit(d[k], 8, -1);
    send_bit(d[4], 4, -1);
    #2 rst = 1'b1;
    #1;
    exp_pdata = 8'h00;
    total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got %b expected 0", bus.busy); else passed++;
    total++; if (bus.p_data !== 8'h00) $display("FAIL mid_rst_p_data got %h expected 00", bus.p_data); else passed++;
    total++; if (bus.data_valid !== 1'b0 || bus.par_err !== 1'b0 || bus.stp_err !== 1'b0)
      $display("FAIL mid_rst_pulses got %b%b%b expected 000", bus.data_valid, bus.par_err, bus.stp_err); else passed++;
    @(negedge clk);
    bus.rx_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_stale_low got %b expected 0", bus.busy); else passed++;
    idle(6);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    exp_pdata = 8'h81;
    total++; if (dv_total - dv0 !== 1) $display("FAIL mid_rst_dv got %0d expected 1", dv_total - dv0); else passed++;
    total++; if (last_data !== 8'h81) $display("FAIL mid_rst_data got %h expected 81", last_data); else passed++;
    total++; if (pe_total != pe0 || se_total != se0)
      $display("FAIL mid_rst_errs got pe=%0d se=%0d expected 0 0", pe_total - pe0, se_total - se0); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_in = 1'b1;
    set_cfg(6'd8, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    test_reset();
`ifdef UART_RX_PARITY_CHECK_EN
    test_even_parity();
    test_odd_parity();
`else
    test_parity_ignored();
`endif
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_presc_change();
    test_illegal_presc();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
